ga_crossover_mutate: RTL and testbench

GA offspring generator that sits directly downstream of the LFSR random source.
- Accepts two parent chromosomes over a valid/ready handshake.
- Performs single-point crossover at a random cut point, then per-bit mutation, consuming one fresh LFSR byte per cycle.
- Presents the child chromosome and its mutation count over a valid/ready handshake to the population/fitness stage.

---
 rtl/ga_crossover_mutate.sv | 136 +++++++++++++
 tb/tb_ga_crossover_mutate.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_crossover_mutate.sv
// GA offspring generator: single-point crossover at a random cut, then per-bit mutation
// driven by one fresh LFSR byte per cycle, with valid/ready handshakes on both sides.
module ga_crossover_mutate #(
  parameter int unsigned CHROM_W = 8,
  parameter int unsigned IDX_W   = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         RAND_IN,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [CHROM_W-1:0] PARENT_A,
  input  logic [CHROM_W-1:0] PARENT_B,
  input  logic [7:0]         MUT_RATE,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [CHROM_W-1:0] CHILD,
  output logic [IDX_W:0]     MUT_COUNT,
  output logic               BUSY
);

  typedef enum logic [1:0] {StIdle, StCross, StMutate, StDone} state_e;

  localparam logic [IDX_W:0]   ChromWidth = (IDX_W+1)'(CHROM_W);
  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(CHROM_W - 1);

  state_e state_q, state_d;

  logic [CHROM_W-1:0] par_a_q, par_a_d;
  logic [CHROM_W-1:0] par_b_q, par_b_d;
  logic [7:0]         rate_q, rate_d;
  logic [CHROM_W-1:0] child_q, child_d;
  logic [IDX_W:0]     mut_count_q, mut_count_d;
  logic [IDX_W-1:0]   k_q, k_d;

  logic [IDX_W:0]     cut_raw;
  logic [IDX_W:0]     cut;
  logic [CHROM_W-1:0] cross_mask;
  logic               flip;

  // A raw index of at most 2*CHROM_W-1 folds back into range with one subtract.
  assign cut_raw = {1'b0, RAND_IN[IDX_W-1:0]};
  assign cut     = (cut_raw >= ChromWidth) ? cut_raw - ChromWidth : cut_raw;
  assign flip    = (RAND_IN < rate_q);

  always_comb begin
    cross_mask = '0;
    for (int unsigned i = 0; i < CHROM_W; i++) begin
      cross_mask[i] = ((IDX_W+1)'(i) < cut);
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (IN_VALID) state_d = StCross;
      StCross:  state_d = StMutate;
      StMutate: if (k_q == LastIdx) state_d = StDone;
      StDone:   if (OUT_READY) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    IN_READY  = (state_q == StIdle);
    OUT_VALID = (state_q == StDone);
    BUSY      = (state_q != StIdle);
  end

  assign CHILD     = child_q;
  assign MUT_COUNT = mut_count_q;

  // Datapath next-state
  always_comb begin
    par_a_d     = par_a_q;
    par_b_d     = par_b_q;
    rate_d      = rate_q;
    child_d     = child_q;
    mut_count_d = mut_count_q;
    k_d         = k_q;
    unique case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          par_a_d = PARENT_A;
          par_b_d = PARENT_B;
          rate_d  = MUT_RATE;
        end
      end
      StCross: begin
        child_d     = (par_a_q & cross_mask) | (par_b_q & ~cross_mask);
        mut_count_d = '0;
        k_d         = '0;
      end
      StMutate: begin
        if (flip) begin
          child_d[k_q] = ~child_q[k_q];
          mut_count_d  = mut_count_q + (IDX_W+1)'(1);
        end
        if (k_q != LastIdx) begin
          k_d = k_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_a_q     <= '0;
      par_b_q     <= '0;
      rate_q      <= '0;
      child_q     <= '0;
      mut_count_q <= '0;
      k_q         <= '0;
    end else begin
      par_a_q     <= par_a_d;
      par_b_q     <= par_b_d;
      rate_q      <= rate_d;
      child_q     <= child_d;
      mut_count_q <= mut_count_d;
      k_q         <= k_d;
    end
  end

endmodule

// File: tb/tb_ga_crossover_mutate.sv
// Bench for ga_crossover_mutate: table of parent/random-byte vectors with expected children,
// scoreboard queue popped on the output handshake, plus backpressure and mid-run reset sequences.
module tb_ga_crossover_mutate;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  rate;
    logic [71:0] rnd;   // byte 0: cross cut, bytes 1..8: mutate k=0..7
    logic [7:0]  child;
    logic [3:0]  cnt;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RAND_IN = 8'h00;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] PARENT_A = 8'h00;
  logic [7:0] PARENT_B = 8'h00;
  logic [7:0] MUT_RATE = 8'h00;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] CHILD;
  logic [3:0] MUT_COUNT;
  logic       BUSY;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_child_q[$];
  logic [3:0] exp_cnt_q[$];

  localparam int NumVec = 15;
  vec_t tbl[NumVec];

  ga_crossover_mutate #(.CHROM_W(8), .IDX_W(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RAND_IN   (RAND_IN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .PARENT_A  (PARENT_A),
    .PARENT_B  (PARENT_B),
    .MUT_RATE  (MUT_RATE),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .CHILD     (CHILD),
    .MUT_COUNT (MUT_COUNT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] rate,
                              input logic [71:0] rnd, input logic [7:0] child,
                              input logic [3:0] cnt);
    vec_t v;
    v.a = a; v.b = b; v.rate = rate; v.rnd = rnd; v.child = child; v.cnt = cnt;
    return v;
  endfunction

  // Reference: cut p = rnd[2:0] (always < 8), low p bits from A, then mutate bit k on byte k+1.
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] rate, input logic [71:0] rnd);
    vec_t v;
    int   p;
    logic [7:0] by;
    v.a = a; v.b = b; v.rate = rate; v.rnd = rnd; v.cnt = 4'd0;
    p = int'(rnd[2:0]);
    for (int i = 0; i < 8; i++) v.child[i] = (i < p) ? a[i] : b[i];
    for (int k = 0; k < 8; k++) begin
      by = rnd[8*(k+1) +: 8];
      if (by < rate) begin
        v.child[k] = ~v.child[k];
        v.cnt = v.cnt + 4'd1;
      end
    end
    return v;
  endfunction

  task automatic start_txn(input vec_t v, input bit push);
    chk("in_ready_before_accept", {31'd0, IN_READY}, 32'd1);
    PARENT_A = v.a;
    PARENT_B = v.b;
    MUT_RATE = v.rate;
    IN_VALID = 1'b1;
    RAND_IN  = 8'h5A;
    step();
    // Scramble inputs after acceptance; the latched copies must be used.
    IN_VALID = 1'b0;
    PARENT_A = ~v.a;
    PARENT_B = ~v.b;
    MUT_RATE = ~v.rate;
    chk("busy_after_accept", {31'd0, BUSY}, 32'd1);
    chk("in_ready_after_accept", {31'd0, IN_READY}, 32'd0);
    if (push) begin
      exp_child_q.push_back(v.child);
      exp_cnt_q.push_back(v.cnt);
    end
  endtask

  // Feeds the random bytes, waits for OUT_VALID, optionally stalls, then completes the handshake.
  task automatic run_to_done(input vec_t v, input int hold, input bit chk_lat, input vec_t nxt);
    int n;
    bit seen;
    logic [7:0] ec;
    logic [3:0] en;
    n = 0;
    seen = 1'b0;
    while (n < 30) begin
      if (OUT_VALID) begin
        seen = 1'b1;
        break;
      end
      RAND_IN = (n < 9) ? v.rnd[8*n +: 8] : 8'($urandom);
      step();
      n++;
    end
    chk("out_valid_seen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    if (chk_lat) chk("out_valid_cycle", 32'(n + 1), 32'd10);
    if (exp_child_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    ec = exp_child_q.pop_front();
    en = exp_cnt_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      PARENT_A  = nxt.a;
      PARENT_B  = nxt.b;
      MUT_RATE  = nxt.rate;
      RAND_IN   = 8'($urandom);
      chk("hold_out_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("hold_in_ready", {31'd0, IN_READY}, 32'd0);
      chk("hold_child", {24'd0, CHILD}, {24'd0, ec});
      chk("hold_mut_count", {28'd0, MUT_COUNT}, {28'd0, en});
      step();
    end
    OUT_READY = 1'b1;
    chk("child", {24'd0, CHILD}, {24'd0, ec});
    chk("mut_count", {28'd0, MUT_COUNT}, {28'd0, en});
    step();
    OUT_READY = 1'b0;
    chk("idle_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("idle_in_ready", {31'd0, IN_READY}, 32'd1);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    vec_t nv;
    vec_t bp_next;

    tbl[0] = mk(8'hFF, 8'h00, 8'h00, {64'h0, 8'h03}, 8'h07, 4'd0);
    tbl[1] = mk(8'hAA, 8'hAA, 8'hFF, {9{8'h00}}, 8'h55, 4'd8);
    tbl[2] = mk(8'hAA, 8'hAA, 8'hFF, {9{8'hFF}}, 8'hAA, 4'd0);
    tbl[3] = mk(8'h00, 8'h00, 8'h80, {{4{8'h90, 8'h10}}, 8'h00}, 8'h55, 4'd4);
    tbl[4] = mk(8'h00, 8'h00, 8'h80, {9{8'h80}}, 8'h00, 4'd0);
    tbl[5] = mk(8'h00, 8'h00, 8'h80, {9{8'h7F}}, 8'hFF, 4'd8);
    tbl[6] = mk(8'h3C, 8'hC3, 8'h00, {64'h0, 8'h06}, 8'hFC, 4'd0);
    tbl[7] = mk(8'hF0, 8'h0F, 8'h00, {64'h0, 8'h05}, 8'h10, 4'd0);
    tbl[8] = mk(8'h0F, 8'hF0, 8'h40, {{4{8'h40, 8'h3F}}, 8'h02}, 8'hA6, 4'd4);
    for (int i = 9; i < NumVec; i++) begin
      tbl[i] = model(8'($urandom), 8'($urandom), 8'($urandom),
                     {8'($urandom), $urandom, $urandom});
    end

    // Reset held: outputs at reset values even with IN_VALID asserted
    RST = 1'b0;
    IN_VALID = 1'b1;
    PARENT_A = 8'h12;
    repeat (3) step();
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_child", {24'd0, CHILD}, 32'd0);
    chk("rst_mut_count", {28'd0, MUT_COUNT}, 32'd0);
    IN_VALID = 1'b0;
    RST = 1'b1;
    step();
    chk("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);
    chk("post_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("post_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("post_rst_child", {24'd0, CHILD}, 32'd0);

    for (int i = 0; i < NumVec; i++) begin
      start_txn(tbl[i], 1'b1);
      run_to_done(tbl[i], 0, 1'b1, tbl[i]);
    end

    // Backpressure: stall 5 cycles with new parents waiting, then they go in right after
    bp_next = model(8'hC5, 8'h3A, 8'h60, {8'h11, 8'h70, 8'h22, 8'h99, 8'h5F, 8'h60, 8'h00,
                                          8'hFF, 8'h04});
    start_txn(tbl[8], 1'b1);
    run_to_done(tbl[8], 5, 1'b1, bp_next);
    start_txn(bp_next, 1'b1);
    run_to_done(bp_next, 0, 1'b1, bp_next);

    // Reset during MUTATE at k=4: in-flight child discarded
    start_txn(tbl[3], 1'b0);
    for (int n = 0; n < 6; n++) begin
      RAND_IN = tbl[3].rnd[8*n +: 8];
      step();
    end
    RST = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, IN_READY}, 32'd1);
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    chk("midrst_child", {24'd0, CHILD}, 32'd0);
    chk("midrst_mut_count", {28'd0, MUT_COUNT}, 32'd0);
    OUT_READY = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("midrst_no_out_valid", {31'd0, OUT_VALID}, 32'd0);
    end
    OUT_READY = 1'b0;
    RST = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      chk("postrst_no_out_valid", {31'd0, OUT_VALID}, 32'd0);
    end
    nv = tbl[1];
    start_txn(nv, 1'b1);
    run_to_done(nv, 0, 1'b1, nv);

    chk("scoreboard_drained", 32'(exp_child_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
